// File: rtl/kernel_jacobi_2d_idx_seq.sv
// Interior-point (i, j) sweep for Jacobi-2D: drives i and N into an external
// ce-gated multiplier and forms the linear address i*N + j as products return.
module kernel_jacobi_2d_idx_seq #(
  parameter int ROW_W    = 10,
  parameter int STRIDE_W = 11,
  parameter int PROD_W   = 20,
  parameter int ADDR_W   = 20,
  parameter int MUL_LAT  = 3
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                start,
  input  logic [ROW_W-1:0]    n_dim,
  output logic                busy,
  output logic                done,
  output logic                mul_ce,
  output logic [ROW_W-1:0]    mul_din0,
  output logic [STRIDE_W-1:0] mul_din1,
  input  logic [PROD_W-1:0]   mul_dout,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_valid,
  input  logic                addr_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic [ROW_W-1:0]    n_q;
  logic [ROW_W-1:0]    i_q;
  logic [ROW_W-1:0]    j_q;
  logic [ROW_W-1:0]    last_idx;
  logic                issue;
  logic                upstream_valid;

  // Delay line mirrors the multiplier's internal registers, one entry per stage.
  logic                dl_valid [MUL_LAT];
  logic [STRIDE_W-1:0] dl_col   [MUL_LAT];

  assign last_idx   = n_q - ROW_W'(2);
  assign addr_valid = dl_valid[MUL_LAT-1];
  assign mul_ce     = !(addr_valid && !addr_ready);
  assign issue      = (state == ISSUE) && mul_ce;
  assign mul_din0   = (state == ISSUE) ? i_q : '0;
  assign mul_din1   = (state == ISSUE) ? STRIDE_W'(n_q) : '0;
  assign addr_out   = ADDR_W'(mul_dout) + ADDR_W'(dl_col[MUL_LAT-1]);

  // Any valid entry still travelling towards the output stage.
  always_comb begin
    upstream_valid = 1'b0;
    for (int unsigned k = 0; k < MUL_LAT - 1; k++) begin
      upstream_valid = upstream_valid | dl_valid[k];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        dl_valid[k] <= 1'b0;
        dl_col[k]   <= '0;
      end
    end else if (mul_ce) begin
      dl_valid[0] <= issue;
      dl_col[0]   <= STRIDE_W'(j_q);
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        dl_valid[k] <= dl_valid[k-1];
        dl_col[k]   <= dl_col[k-1];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      n_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q  <= n_dim;
            i_q  <= ROW_W'(1);
            j_q  <= ROW_W'(1);
            busy <= 1'b1;
            if (n_dim >= ROW_W'(3)) begin
              state <= ISSUE;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mul_ce) begin
            if (j_q == last_idx) begin
              j_q <= ROW_W'(1);
              i_q <= i_q + ROW_W'(1);
              if (i_q == last_idx) state <= DRAIN;
            end else begin
              j_q <= j_q + ROW_W'(1);
            end
          end
        end
        DRAIN: begin
          // With ce high and nothing upstream, the output stage empties on this edge.
          if (mul_ce && !upstream_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_jacobi_2d_idx_seq.sv
// Bench for kernel_jacobi_2d_idx_seq: behavioural multiplier plus an arithmetic
// address model, with directed and randomized backpressure sweeps.
module tb_kernel_jacobi_2d_idx_seq;
  localparam int ROW_W    = 10;
  localparam int STRIDE_W = 11;
  localparam int PROD_W   = 20;
  localparam int ADDR_W   = 20;
  localparam int MUL_LAT  = 3;

  logic                ap_clk = 1'b0;
  logic                ap_rst = 1'b1;
  logic                start  = 1'b0;
  logic [ROW_W-1:0]    n_dim  = '0;
  logic                busy, done, mul_ce, addr_valid;
  logic                addr_ready = 1'b1;
  logic [ROW_W-1:0]    mul_din0;
  logic [STRIDE_W-1:0] mul_din1;
  logic [PROD_W-1:0]   mul_dout;
  logic [ADDR_W-1:0]   addr_out;

  kernel_jacobi_2d_idx_seq #(
    .ROW_W(ROW_W), .STRIDE_W(STRIDE_W), .PROD_W(PROD_W), .ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .n_dim(n_dim),
    .busy(busy), .done(done), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // Behavioural 3-stage ce-gated multiplier, deliberately not reset.
  logic [PROD_W-1:0] mp [3];
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      mp[0] <= PROD_W'(mul_din0) * PROD_W'(mul_din1);
      mp[1] <= mp[0];
      mp[2] <= mp[1];
    end
  end
  assign mul_dout = mp[2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k-th interior point in row-major order.
  function automatic longint exp_addr(input int n, input int k);
    int m;
    m = n - 2;
    return longint'(1 + k / m) * n + longint'(1 + k % m);
  endfunction

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  bit                mon_on = 0;
  int                c0, done_cyc, first_valid, busy_cnt, stall_cnt, done_cnt;
  bit                prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] got_q [$];

  always @(negedge ap_clk) begin
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - c0;
      end
      if (addr_valid && first_valid < 0) first_valid = cyc - c0;
      if (prev_stall) begin
        check("stall_hold_valid", addr_valid, 1);
        check("stall_hold_addr", addr_out, prev_addr);
      end
      if (addr_valid && !addr_ready) begin
        check("stall_ce", mul_ce, 0);
        stall_cnt++;
      end
      if (addr_valid && addr_ready) got_q.push_back(addr_out);
      prev_stall = addr_valid && !addr_ready;
      prev_addr  = addr_out;
    end
  end

  // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 5-7.
  task automatic sweep(input int n, input int rmode, input bit repulse, input int rst_at);
    int limit, rel, exp_done, m, v, dn;
    m = (n >= 3) ? n - 2 : 0;
    limit = (rst_at > 0) ? rst_at : m * m * 5 + 40;
    got_q.delete();
    done_cyc = -1; first_valid = -1; busy_cnt = 0; stall_cnt = 0; done_cnt = 0;
    prev_stall = 0;
    @(posedge ap_clk); #1;
    addr_ready = 1'b1;
    start = 1'b1;
    n_dim = ROW_W'(n);
    c0 = cyc;
    mon_on = 1;
    rel = 0;
    while (rel < limit && !(done_cyc >= 0 && rel > done_cyc + 2)) begin
      @(posedge ap_clk); #1;
      rel++;
      start = 1'b0;
      case (rmode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = ($urandom_range(0, 3) != 0);
        default: addr_ready = !(rel >= 5 && rel <= 7);
      endcase
      if (repulse && rel == 3) begin
        start = 1'b1;
        n_dim = ROW_W'(n + 3);
      end
    end
    if (rst_at > 0) begin
      mon_on = 0;
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("rst_busy", busy, 0);
      check("rst_valid", addr_valid, 0);
      v = 0; dn = 0;
      repeat (8) begin
        @(negedge ap_clk);
        v += int'(addr_valid);
        dn += int'(done);
      end
      check("rst_stale_valid", v, 0);
      check("rst_no_done", dn + done_cnt, 0);
      for (int k = 0; k < got_q.size(); k++) check("rst_prefix_addr", got_q[k], exp_addr(n, k));
      return;
    end
    mon_on = 0;
    exp_done = (n < 3) ? 1 : m * m + 4 + stall_cnt;
    check("done_cycle", done_cyc, exp_done);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, exp_done);
    check("addr_count", got_q.size(), m * m);
    if (n >= 3) check("first_valid", first_valid, 4);
    for (int k = 0; k < got_q.size() && k < m * m; k++) check("addr", got_q[k], exp_addr(n, k));
  endtask

  initial begin
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", addr_valid, 0);
    check("reset_ce", mul_ce, 1);
    check("reset_din0", mul_din0, 0);
    check("reset_din1", mul_din1, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    sweep(4, 0, 0, 0);
    check("n4_done_cycle", done_cyc, 8);
    sweep(5, 2, 0, 0);
    check("n5_stall_cycles", stall_cnt, 3);
    check("n5_done_cycle", done_cyc, 16);
    sweep(2, 0, 0, 0);
    sweep(0, 0, 0, 0);
    sweep(3, 0, 0, 0);
    check("n3_done_cycle", done_cyc, 5);
    sweep(5, 0, 1, 0);
    sweep(6, 0, 0, 6);
    sweep(4, 0, 0, 0);
    sweep(1023, 1, 0, 400);
    repeat (6) sweep(int'($urandom_range(3, 24)), 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kernel_jacobi_2d_idx_seq.md
# kernel_jacobi_2d_idx_seq

Interior-point index sequencer and address former for the Jacobi-2D kernel. It sweeps every interior grid point (i, j), 1 ≤ i, j ≤ N-2, in row-major order. For each point it drives the row index and stride into the kernel's 3-stage ce-gated unsigned multiplier (10b × 11b → 20b) and carries j alongside in a matching delay line. When the product returns it adds the column and emits the linear address i*N + j to the stencil load stage over a valid/ready handshake.

## Interface
- ROW_W, default 10: row index width; multiplier din0 width.
- STRIDE_W, default 11: stride width; multiplier din1 width; also the column width.
- PROD_W, default 20: multiplier dout width.
- ADDR_W, default 20: output address width.
- MUL_LAT, default 3: multiplier latency in ce-enabled clock edges.
- ap_clk  in  1  sole clock; all state changes on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- start  in  1  sampled only in IDLE; launches one sweep.
- n_dim  in  ROW_W  grid dimension N; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a sweep.
- mul_ce  out  1  clock enable to the multiplier.
- mul_din0  out  ROW_W  row index i to the multiplier.
- mul_din1  out  STRIDE_W  stride N, zero-extended, to the multiplier.
- mul_dout  in  PROD_W  product from the multiplier.
- addr_out  out  ADDR_W  linear address i*N + j.
- addr_valid  out  1  addr_out is valid.
- addr_ready  in  1  consumer accepts the address.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
  - IDLE: on start, latch n_dim and set i=1, j=1. If N ≥ 3 go to ISSUE, otherwise go straight to DONE. No address is emitted when N < 3.
  - ISSUE: on each cycle with mul_ce=1, drive din0=i and din1=N, push (valid=1, col=j) into the delay line, then advance the counters. j increments; when j == N-2 it wraps to 1 and i increments. When the issue has i == N-2 and j == N-2, go to DRAIN.
  - DRAIN: issue nothing, and push valid=0 on each mul_ce cycle. Go to DONE once the delay line holds no valid entry and no address is pending.
  - DONE: assert done for one cycle, then go to IDLE.
- Delay line: MUL_LAT stages of {valid, col}, shifted only when mul_ce=1, so it stays aligned with the multiplier's internal registers.
  - addr_valid = valid of the last stage.
  - addr_out = mul_dout + col of the last stage. Width is ADDR_W and the value never overflows: the maximum is 1021*1023 + 1021 = 1,045,504 < 2^20.
- Backpressure: mul_ce = !(addr_valid && !addr_ready). A stall freezes the multiplier, the delay line and the i/j counters together.
- Transfer occurs when addr_valid && addr_ready. addr_out and addr_valid stay stable while stalled.
- start is ignored while busy. n_dim is ignored except on an accepted start.
- mul_din0 and mul_din1 are driven to 0 outside ISSUE.

## Timing
- Reset values: busy=0, done=0, addr_valid=0, mul_din0=0, mul_din1=0, state=IDLE, all delay-line valids cleared. mul_ce=1 during and after reset, because it follows from addr_valid=0. addr_out is don't-care while addr_valid=0.
- Assertion of ap_rst mid-sweep: the next cycle is IDLE with the delay line cleared. Stale products in the multiplier are never presented as valid. No done pulse is produced.
- Cycle numbering: start is sampled at the edge ending cycle 0.
  - busy=1 from cycle 1.
  - The first issue is presented in cycle 1.
  - The first addr_valid appears in cycle 1 + MUL_LAT = 4.
- With addr_ready held high, throughput is one address per cycle. The last address is valid in cycle (N-2)^2 + 3, and done pulses in the following cycle.
- With N < 3: done is in cycle 1 and busy is high for cycle 1 only.
- A stall of k cycles delays every later event, including done, by exactly k cycles.

## Test plan
- N=4, addr_ready=1: start in cycle 0 → addresses 5, 6, 9, 10 valid in cycles 4–7; done in cycle 8; busy high in cycles 1–8.
- N=5, addr_ready held low in cycles 5–7: addresses 6, 7, 8, 11, 12, 13, 16, 17, 18 in order, with none dropped or duplicated; addr_out stable and mul_ce=0 during the stall; done in cycle 16.
- N=2 and N=0: done in cycle 1, no addr_valid ever; then start with N=3 → a single address 4 in cycle 4, done in cycle 5.
- N=1023, random addr_ready: 1,042,441 addresses; the last is 1,045,504; each address equals the previous +1, except at row wrap where it jumps by +3.
- start pulsed again during a sweep with a different n_dim: ignored, and the sequence matches the original N.
- ap_rst asserted in cycle 6 of an N=6 sweep: from cycle 7 busy=0 and addr_valid=0; a restart with N=4 yields exactly 5, 6, 9, 10.
